// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: ALU select codes and the FSM state encoding.
// The external ALU decodes the same opcode constants.
package alu_sequencer_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_MOD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Operand register file: NREG x DW, two combinational read ports, one write port.
// Asynchronous active-low clear of every entry.
module alu_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [RW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [RW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [RW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer in front of an external combinational ALU: loads registers, issues
// one ALU operation per command and presents the result through a valid/ready port.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [2:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rs1,
    input  logic [RW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [RW-1:0] res_rd,
    output logic          res_err
);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    logic [2:0]    r_op;
    logic [RW-1:0] r_rd;
    logic [RW-1:0] r_rs1;
    logic [RW-1:0] r_rs2;
    logic [DW-1:0] r_res_data;
    logic [RW-1:0] r_res_rd;
    logic          r_res_err;

    logic          w_accept;
    logic          w_we;
    logic [RW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata_a;
    logic [DW-1:0] w_rdata_b;
    logic          w_mod_zero;

    // Registers only change on a load accept or at the end of EXEC, so reading them
    // during EXEC returns exactly the values present at the accept edge.
    alu_regfile #(.DW(DW), .NREG(NREG), .RW(RW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_rs1),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (r_rs2),
        .o_rdata_b (w_rdata_b)
    );

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_mod_zero = (r_op == ALU_MOD) && (w_rdata_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = '0;
        w_we        = 1'b0;
        w_waddr     = r_rd;
        w_wdata     = alu_out;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_load) begin
                        w_we        = 1'b1;
                        w_waddr     = cmd_rd;
                        w_wdata     = cmd_imm;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                alu_a       = w_rdata_a;
                alu_b       = w_rdata_b;
                alu_sel     = r_op;
                w_we        = !w_mod_zero;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_res_data <= '0;
            r_res_rd   <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_op;
                r_rd  <= cmd_rd;
                r_rs1 <= cmd_rs1;
                r_rs2 <= cmd_rs2;
                if (cmd_load) begin
                    r_res_data <= cmd_imm;
                    r_res_rd   <= cmd_rd;
                    r_res_err  <= 1'b0;
                end
            end
            if (r_state == ST_EXEC) begin
                r_res_data <= w_mod_zero ? '1 : alu_out;
                r_res_rd   <= r_rd;
                r_res_err  <= w_mod_zero;
            end
        end
    end

    assign res_data = r_res_data;
    assign res_rd   = r_res_rd;
    assign res_err  = r_res_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a transaction-level reference model checked every cycle,
// directed scenarios with hand-computed values, and randomized command traffic.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [15:0] cmd_imm = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [1:0]  res_rd;
    logic        res_err;

    int n_chk = 0;
    int n_fail = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.DW(16), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_err(res_err)
    );

    // Arithmetic reference; mod-by-zero returns a marker the sequencer must override.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SHL: r = a << b;
            ALU_SHR: r = a >> b;
            ALU_MUL: r = a * b;
            default: r = (b == 16'h0) ? 16'h5A5A : a % b;
        endcase
        return r;
    endfunction

    always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: register contents plus the pending command, advanced per edge.
    logic [15:0] m_reg [4];
    int          m_phase;      // 0 waiting for command, 1 operation in flight, 2 result offered
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_dst;
    logic [15:0] m_data;
    logic [1:0]  m_rd;
    logic        m_err;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
                m_phase = 0; m_data = 16'h0; m_rd = 2'd0; m_err = 1'b0;
                m_op = 3'd0; m_a = 16'h0; m_b = 16'h0; m_dst = 2'd0;
            end else if (m_phase == 0) begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        m_reg[cmd_rd] = cmd_imm;
                        m_data = cmd_imm; m_rd = cmd_rd; m_err = 1'b0;
                        m_phase = 2;
                    end else begin
                        m_op = cmd_op; m_dst = cmd_rd;
                        m_a = m_reg[cmd_rs1]; m_b = m_reg[cmd_rs2];
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_rd = m_dst;
                if (m_op == ALU_MOD && m_b == 16'h0) begin
                    m_data = 16'hFFFF; m_err = 1'b1;
                end else begin
                    m_data = alu_fn(m_op, m_a, m_b); m_err = 1'b0;
                    m_reg[m_dst] = m_data;
                end
                m_phase = 2;
            end else if (res_ready) begin
                m_phase = 0;
            end
            #1;
            if (!done) begin
                chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
                chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
                chk("alu_a", 32'(alu_a), (m_phase == 1) ? 32'(m_a) : 32'h0);
                chk("alu_b", 32'(alu_b), (m_phase == 1) ? 32'(m_b) : 32'h0);
                chk("alu_sel", 32'(alu_sel), (m_phase == 1) ? 32'(m_op) : 32'h0);
                if (m_phase != 1) begin
                    chk("res_data", 32'(res_data), 32'(m_data));
                    chk("res_rd", 32'(res_rd), 32'(m_rd));
                    chk("res_err", 32'(res_err), 32'(m_err));
                end
            end
        end
    end

    // Issues one command with res_ready high; returns result and edges from accept to valid.
    task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [15:0] imm, output logic [15:0] data,
                           output logic err, output int lat);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; res_ready = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; data = 16'h0; err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (res_valid) begin
                lat = k; data = res_data; err = res_err;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            n_chk++; n_fail++;
            $display("FAIL result_timeout at %0t: actual=no res_valid required=res_valid", $time);
        end
    endtask

    task automatic readback(input logic [1:0] r, input logic [15:0] exp, input string name);
        logic [15:0] d; logic e; int l;
        run_cmd(1'b0, ALU_OR, r, r, r, 16'h0, d, e, l);
        chk(name, 32'(d), 32'(exp));
    endtask

    initial begin
        logic [15:0] d; logic e; int l;
        int accepts, last_acc, rst_hold;

        repeat (2) @(negedge clk);
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_res_data", 32'(res_data), 32'h0);
        chk("reset_alu_sel", 32'(alu_sel), 32'h0);
        rst_n = 1'b1;

        // Add with load latency and ALU latency pinned by hand.
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 16'h0003, d, e, l);
        chk("load_latency", 32'(l), 32'd1);
        chk("load_data", 32'(d), 32'h0003);
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 16'h0005, d, e, l);
        run_cmd(1'b0, ALU_ADD, 2'd2, 2'd0, 2'd1, 16'h0, d, e, l);
        chk("add_data", 32'(d), 32'h0008);
        chk("add_err", 32'(e), 32'h0);
        chk("alu_latency", 32'(l), 32'd2);
        readback(2'd2, 16'h0008, "add_dest_r2");

        // Modulo by zero: flagged, all-ones, destination untouched.
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 16'h0007, d, e, l);
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 16'h0000, d, e, l);
        run_cmd(1'b0, ALU_MOD, 2'd3, 2'd0, 2'd1, 16'h0, d, e, l);
        chk("modz_data", 32'(d), 32'hFFFF);
        chk("modz_err", 32'(e), 32'h1);
        readback(2'd3, 16'h0000, "modz_r3_unchanged");

        // Truncating multiply into one of its own sources.
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 16'h8000, d, e, l);
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 16'h0002, d, e, l);
        run_cmd(1'b0, ALU_MUL, 2'd0, 2'd0, 2'd1, 16'h0, d, e, l);
        chk("mul_trunc", 32'(d), 32'h0000);
        readback(2'd0, 16'h0000, "mul_r0");
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 16'h0003, d, e, l);
        run_cmd(1'b0, ALU_SUB, 2'd1, 2'd1, 2'd0, 16'h0, d, e, l);
        chk("sub_self_src", 32'(d), 32'h0003);

        // Stall in the result phase while another command is offered.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 2'd2; cmd_imm = 16'h1234; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_imm = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(res_valid), 32'h1);
            chk("stall_data", 32'(res_data), 32'h1234);
            chk("stall_ready", 32'(cmd_ready), 32'h0);
            @(negedge clk);
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        chk("release_idle", 32'(cmd_ready), 32'h1);
        readback(2'd2, 16'h1234, "stall_r2");

        // Reset while an add into R1 is executing.
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 16'h0005, d, e, l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = ALU_ADD;
        cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_sel_add", 32'(alu_sel), 32'(ALU_ADD));
        chk("exec_a", 32'(alu_a), 32'h0005);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_alu_a", 32'(alu_a), 32'h0);
        chk("rst_exec_valid", 32'(res_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_exec_idle", 32'(cmd_ready), 32'h1);
        readback(2'd1, 16'h0000, "rst_exec_r1");

        // Back-to-back ALU commands: one accept every third edge.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; res_ready = 1'b1;
        accepts = 0; last_acc = -3;
        for (int i = 0; i < 30; i++) begin
            cmd_op = 3'($urandom_range(0, 7));
            cmd_rd = 2'($urandom_range(0, 3));
            cmd_rs1 = 2'($urandom_range(0, 3));
            cmd_rs2 = 2'($urandom_range(0, 3));
            if (cmd_ready) begin
                chk("b2b_gap", 32'(i - last_acc), 32'd3);
                last_acc = i;
                accepts++;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(accepts), 32'd10);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic with occasional resets.
        rst_hold = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                rst_hold = 1;
            end
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_load = ($urandom_range(0, 2) == 0);
            cmd_op = 3'($urandom_range(0, 7));
            cmd_rd = 2'($urandom_range(0, 3));
            cmd_rs1 = 2'($urandom_range(0, 3));
            cmd_rs2 = 2'($urandom_range(0, 3));
            cmd_imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
        repeat (4) @(negedge clk);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DW, 16, operand/result width.
REQ-002 Parameter NREG, 4, number of operand registers; register index width RW = clog2(NREG).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_load  input  1  1 = load cmd_imm into register cmd_rd; 0 = ALU operation.
REQ-008 cmd_op  input  3  ALU select code: 000 add, 001 sub, 010 and, 011 or, 100 shl, 101 shr, 110 mul, 111 mod.
REQ-009 cmd_rd / cmd_rs1 / cmd_rs2  input  RW each  destination and source register indices.
REQ-010 cmd_imm  input  DW  load data.
REQ-011 alu_a, alu_b  output  DW each  operands driven to the external combinational ALU.
REQ-012 alu_sel  output  3  select driven to the external ALU.
REQ-013 alu_out  input  DW  combinational ALU result.
REQ-014 res_valid  output  1  result available; res_ready  input  1  consumer accepts.
REQ-015 res_data  output  DW, res_rd  output  RW, res_err  output  1  result, destination, mod-by-zero flag.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: cmd_ready=1; handshake when cmd_valid&cmd_ready; all cmd_* fields captured at that edge.
REQ-018 Accepted load: next state RESP; register rd <= cmd_imm; res_data=cmd_imm, res_err=0.
REQ-019 Accepted ALU op: next state EXEC; operands read from register file at capture (values of registers at the accept edge).
REQ-020 EXEC lasts exactly one cycle: alu_a=R[rs1], alu_b=R[rs2], alu_sel=op; alu_out registered into res_data at the end of EXEC; next state RESP.
REQ-021 Outside EXEC, alu_a, alu_b, alu_sel SHALL be 0.
REQ-022 Mod with alu_b==0: res_data=all ones, res_err=1, destination register NOT written; otherwise R[rd] <= alu_out at end of EXEC.
REQ-023 RESP: res_valid=1, res_data/res_rd/res_err stable until res_valid&res_ready; then next state IDLE.
REQ-024 cmd_ready=0 in EXEC and RESP; no command accepted until return to IDLE (min ALU-op throughput one per 3 cycles, load one per 2 cycles with res_ready held 1).
REQ-025 Latency: ALU op accepted at edge N -> res_valid high from edge N+2; load accepted at edge N -> res_valid high from edge N+1.
REQ-026 rd equal to rs1 or rs2: sources read before write; result reflects old values.
REQ-027 Arithmetic width: results truncated to DW bits exactly as alu_out delivers; sequencer applies no extension.
REQ-028 res_data, res_rd, res_err hold last values in IDLE; res_valid=0 outside RESP.

Reset
REQ-029 rst_n low (any time, including mid-EXEC or mid-RESP): state IDLE, all registers R[0..NREG-1]=0, res_valid=0, res_data=0, res_rd=0, res_err=0, alu_* outputs=0; in-flight command discarded without register write.
REQ-030 First command accepted on the first rising edge after rst_n deasserts with cmd_valid=1.

Structure
REQ-031 Shared package holds ALU opcode constants (ALU_ADD..ALU_MOD, 3 bits) and FSM state encoding, used by both the ALU and this block.
REQ-032 One sub-module: alu_regfile (NREG x DW, two combinational read ports, one write port, async active-low clear).
REQ-033 The ALU itself is external; the sequencer only drives its ports.

Verification
REQ-034 Load R0=0x0003, load R1=0x0005, op add rd=2 rs1=0 rs2=1 -> res_data=0x0008, res_err=0, R2=0x0008, res_valid at N+2.
REQ-035 R0=0x0007, R1=0x0000, op mod rd=3 -> res_data=0xFFFF, res_err=1, R3 unchanged (0).
REQ-036 R0=0x8000, R1=0x0002 op mul rd=0 rs1=0 rs2=1 -> res_data=0x0000 (truncated), R0=0x0000; sources sampled pre-write.
REQ-037 Hold res_ready=0 for 5 cycles in RESP -> res_valid/res_data stable, cmd_ready=0, cmd_valid ignored; release -> IDLE next cycle.
REQ-038 Assert rst_n low during EXEC of add rd=1 -> state IDLE, R1=0, res_valid=0, no write after deassert.
REQ-039 Back-to-back commands with cmd_valid held high and res_ready=1 -> one accept per 3 cycles, alu_sel matches each op only in its EXEC cycle.
